// File: rtl/iob_eth_tx_serializer.sv
// -----------------------------------------------------------------------------
// iob_eth_tx_serializer
//
// Purpose: reads an Ethernet payload from a 32-bit word buffer and serialises
// it onto a PHY_DW-bit PHY transmit interface. Each frame is sent as a
// preamble (7 x 0x55), an SFD (0xD5), len payload bytes, an optional FCS
// (4 bytes) and then 12 idle byte times of inter-frame gap.
//
// Optional feature: define IOB_ETH_TX_CRC_EN to append the CRC-32 FCS over
// the payload. When it is undefined, the CRC state and logic do not exist.
//
// Parameters:
//   PHY_DW     - PHY data width in bits (2, 4 or 8)
//   BUF_ADDR_W - TX buffer word address width
//
// Ports:
//   clk        in   TX clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   one-cycle request to send the buffered frame (IDLE only)
//   len        in   payload length in bytes, sampled with start
//   busy       out  frame in progress
//   done       out  one-cycle pulse in the last inter-frame-gap cycle
//   buf_addr   out  buffer word read address
//   buf_rdata  in   buffer read data, valid one cycle after buf_addr
//   tx_data    out  PHY transmit data, LS bits of each byte first
//   tx_en      out  PHY transmit enable
//
// All outputs are registered from the current FSM state, so they trail the
// state register by one cycle.
// -----------------------------------------------------------------------------
module iob_eth_tx_serializer #(
  parameter int PHY_DW     = 4,
  parameter int BUF_ADDR_W = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [10:0]           len,
  output logic                  busy,
  output logic                  done,
  output logic [BUF_ADDR_W-1:0] buf_addr,
  input  logic [31:0]           buf_rdata,
  output logic [PHY_DW-1:0]     tx_data,
  output logic                  tx_en
);

  localparam int         NPH     = 8 / PHY_DW;
  localparam logic [2:0] LAST_PH = 3'(NPH - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PREAMBLE,
    SFD,
    DATA,
`ifdef IOB_ETH_TX_CRC_EN
    CRC,
`endif
    IFG
  } state_t;

`ifdef IOB_ETH_TX_CRC_EN
  // Reflected CRC-32 (poly 0x04C11DB7 -> 0xEDB88320) advanced by one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if ((c[0] ^ data[i]) == 1'b1) begin
        c = (c >> 1) ^ 32'hEDB8_8320;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction
`endif

  state_t                state_q, state_d;
  logic [2:0]            phase_q, phase_d;
  logic [10:0]           cnt_q, cnt_d;
  logic [10:0]           len_q, len_d;
  logic [31:0]           word_q, word_d;
  logic [BUF_ADDR_W-1:0] addr_q, addr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  tx_en_q, tx_en_d;
  logic [PHY_DW-1:0]     tx_data_q, tx_data_d;
`ifdef IOB_ETH_TX_CRC_EN
  logic [31:0]           crc_q, crc_d;
  logic [31:0]           fcs_s;
`endif

  logic                  last_ph_s;
  logic                  tx_active_s;
  logic [7:0]            cur_byte_s;
  logic [3:0]            shift_s;
  logic [7:0]            shifted_s;

  assign last_ph_s = (phase_q == LAST_PH);
`ifdef IOB_ETH_TX_CRC_EN
  assign fcs_s = ~crc_q;
`endif

  // Byte currently on the wire and the PHY_DW slice selected by the phase.
  always_comb begin
    cur_byte_s = 8'h00;
    case (state_q)
      PREAMBLE: cur_byte_s = 8'h55;
      SFD:      cur_byte_s = 8'hD5;
      DATA:     cur_byte_s = word_q[{cnt_q[1:0], 3'b000} +: 8];
`ifdef IOB_ETH_TX_CRC_EN
      CRC:      cur_byte_s = fcs_s[{cnt_q[1:0], 3'b000} +: 8];
`endif
      default:  cur_byte_s = 8'h00;
    endcase
    shift_s   = {1'b0, phase_q} * 4'(PHY_DW);
    shifted_s = cur_byte_s >> shift_s;
  end

  // Transmit-enable decode from the current state.
  always_comb begin
    tx_active_s = 1'b0;
    case (state_q)
      PREAMBLE, SFD, DATA: tx_active_s = 1'b1;
`ifdef IOB_ETH_TX_CRC_EN
      CRC:                 tx_active_s = 1'b1;
`endif
      default:             tx_active_s = 1'b0;
    endcase
  end

  // Next-state, counters, buffer prefetch and registered-output inputs.
  always_comb begin
    state_d = state_q;
    phase_d = 3'd0;
    cnt_d   = cnt_q;
    len_d   = len_q;
    word_d  = word_q;
    addr_d  = addr_q;
`ifdef IOB_ETH_TX_CRC_EN
    crc_d   = crc_q;
`endif

    if ((state_q != IDLE) && (state_q != LOAD) && !last_ph_s) begin
      phase_d = phase_q + 3'd1;
    end else begin
      phase_d = 3'd0;
    end

    case (state_q)
      IDLE: begin
        if (start && (len != 11'd0)) begin
          state_d = LOAD;
          len_d   = len;
          addr_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        state_d = PREAMBLE;
        cnt_d   = 11'd0;
`ifdef IOB_ETH_TX_CRC_EN
        crc_d   = 32'hFFFF_FFFF;
`endif
      end
      PREAMBLE: begin
        if (last_ph_s) begin
          if (cnt_q == 11'd6) begin
            state_d = SFD;
            cnt_d   = 11'd0;
          end else begin
            cnt_d = cnt_q + 11'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      SFD: begin
        // Word 0 has been on buf_rdata since LOAD; fetch word 1 only if used.
        if (last_ph_s) begin
          state_d = DATA;
          cnt_d   = 11'd0;
          word_d  = buf_rdata;
          if (len_q > 11'd4) begin
            addr_d = addr_q + 1'b1;
          end else begin
            addr_d = addr_q;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      DATA: begin
        if (last_ph_s) begin
`ifdef IOB_ETH_TX_CRC_EN
          crc_d = crc32_byte(crc_q, cur_byte_s);
`endif
          if (cnt_q == (len_q - 11'd1)) begin
`ifdef IOB_ETH_TX_CRC_EN
            state_d = CRC;
`else
            state_d = IFG;
`endif
            cnt_d = 11'd0;
          end else begin
            cnt_d = cnt_q + 11'd1;
            // Word boundary: the prefetched word is ready; issue the next
            // address only if a later word still holds payload (no wrap).
            if (cnt_q[1:0] == 2'b11) begin
              word_d = buf_rdata;
              if (({1'b0, cnt_q} + 12'd5) < {1'b0, len_q}) begin
                addr_d = addr_q + 1'b1;
              end else begin
                addr_d = addr_q;
              end
            end else begin
              word_d = word_q;
            end
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
`ifdef IOB_ETH_TX_CRC_EN
      CRC: begin
        if (last_ph_s) begin
          if (cnt_q == 11'd3) begin
            state_d = IFG;
            cnt_d   = 11'd0;
          end else begin
            cnt_d = cnt_q + 11'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
`endif
      IFG: begin
        if (last_ph_s) begin
          if (cnt_q == 11'd11) begin
            state_d = IDLE;
            cnt_d   = 11'd0;
          end else begin
            cnt_d = cnt_q + 11'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 11'd0;
      end
    endcase

    tx_en_d   = tx_active_s;
    tx_data_d = tx_active_s ? shifted_s[PHY_DW-1:0] : '0;
    busy_d    = (state_q != IDLE);
    done_d    = (state_q == IFG) && last_ph_s && (cnt_q == 11'd11);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      phase_q   <= 3'd0;
      cnt_q     <= 11'd0;
      len_q     <= 11'd0;
      word_q    <= 32'd0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
`ifdef IOB_ETH_TX_CRC_EN
      crc_q     <= 32'hFFFF_FFFF;
`endif
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      word_q    <= word_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
`ifdef IOB_ETH_TX_CRC_EN
      crc_q     <= crc_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign buf_addr = addr_q;
  assign tx_en    = tx_en_q;
  assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_iob_eth_tx_serializer.sv
// -----------------------------------------------------------------------------
// Testbench for iob_eth_tx_serializer. Three instances (PHY_DW = 2, 4, 8)
// share one buffer memory; each frame is compared cycle by cycle with a
// stream built from the frame format: preamble, SFD, payload bytes read from
// the memory, optional FCS, then the inter-frame gap.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_iob_eth_tx_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] len = 11'd0;
  logic        start2 = 1'b0, start4 = 1'b0, start8 = 1'b0;
  logic        busy2, busy4, busy8, done2, done4, done8, en2, en4, en8;
  logic [8:0]  addr2, addr4, addr8;
  logic [31:0] rdata2, rdata4, rdata8;
  logic [1:0]  td2;
  logic [3:0]  td4;
  logic [7:0]  td8;

  logic [31:0] mem [0:511];

  int checks = 0;
  int errors = 0;
  int sel = 4;

`ifdef IOB_ETH_TX_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic       obs_en, obs_busy, obs_done;
  logic [7:0] obs_data;
  logic [8:0] obs_addr;

  always #5 clk = ~clk;

  // Synchronous-read buffer models, one read port per instance.
  always @(posedge clk) begin
    rdata2 <= mem[addr2];
    rdata4 <= mem[addr4];
    rdata8 <= mem[addr8];
  end

  iob_eth_tx_serializer #(.PHY_DW(2), .BUF_ADDR_W(9)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .len(len), .busy(busy2), .done(done2),
    .buf_addr(addr2), .buf_rdata(rdata2), .tx_data(td2), .tx_en(en2));
  iob_eth_tx_serializer #(.PHY_DW(4), .BUF_ADDR_W(9)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .len(len), .busy(busy4), .done(done4),
    .buf_addr(addr4), .buf_rdata(rdata4), .tx_data(td4), .tx_en(en4));
  iob_eth_tx_serializer #(.PHY_DW(8), .BUF_ADDR_W(9)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .len(len), .busy(busy8), .done(done8),
    .buf_addr(addr8), .buf_rdata(rdata8), .tx_data(td8), .tx_en(en8));

  // Route the instance under test to common observation signals.
  always_comb begin
    case (sel)
      2: begin
        obs_en = en2; obs_busy = busy2; obs_done = done2;
        obs_data = {6'd0, td2}; obs_addr = addr2;
      end
      8: begin
        obs_en = en8; obs_busy = busy8; obs_done = done8;
        obs_data = td8; obs_addr = addr8;
      end
      default: begin
        obs_en = en4; obs_busy = busy4; obs_done = done4;
        obs_data = {4'd0, td4}; obs_addr = addr4;
      end
    endcase
  end

  // Reference CRC-32 (IEEE 802.3, reflected) over a byte queue.
  function automatic logic [31:0] ref_fcs(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      for (int k = 0; k < 8; k++) begin
        c = ((c[0] ^ b[i][k]) == 1'b1) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  task automatic set_start(input int dw, input logic v);
    start2 = (dw == 2) ? v : 1'b0;
    start4 = (dw == 4) ? v : 1'b0;
    start8 = (dw == 8) ? v : 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one frame on the selected instance and checks every cycle up to
  // and including done. mid_at >= 0 pulses start (len mid_len) at that
  // transmit cycle. Called one tick after a rising edge.
  task automatic run_frame(input int dw, input int len_i, input int mid_at, input int mid_len);
    logic [7:0] payload[$];
    logic [7:0] wire_bytes[$];
    logic [31:0] fcs;
    logic [31:0] w;
    logic [7:0] exp_d;
    int nph, nifg, maxw, c;
    sel  = dw;
    nph  = 8 / dw;
    nifg = 12 * nph;
    maxw = (len_i + 3) / 4 - 1;
    for (int k = 0; k < len_i; k++) begin
      w = mem[k / 4];
      payload.push_back(w[8 * (k % 4) +: 8]);
    end
    for (int k = 0; k < 7; k++) wire_bytes.push_back(8'h55);
    wire_bytes.push_back(8'hD5);
    foreach (payload[k]) wire_bytes.push_back(payload[k]);
    if (CRC_ON) begin
      fcs = ref_fcs(payload);
      for (int k = 0; k < 4; k++) wire_bytes.push_back(fcs[8 * k +: 8]);
    end

    set_start(dw, 1'b1);
    len = 11'(len_i);
    step();                                   // edge N
    set_start(dw, 1'b0);
    len = 11'($urandom);
    checks++;
    if ({obs_busy, obs_en} !== 2'b00) begin
      errors++;
      $display("FAIL edge_n dw=%0d busy,en=%b expected 00", dw, {obs_busy, obs_en});
    end
    step();                                   // edge N+1
    checks++;
    if ({obs_busy, obs_en, obs_done, obs_data} !== {3'b100, 8'h00}) begin
      errors++;
      $display("FAIL edge_n1 dw=%0d busy,en,done,data=%b,%b,%b,%h expected 1,0,0,00",
               dw, obs_busy, obs_en, obs_done, obs_data);
    end
    c = 0;
    foreach (wire_bytes[b]) begin
      for (int p = 0; p < nph; p++) begin
        step();
        set_start(dw, 1'b0);
        exp_d = (wire_bytes[b] >> (p * dw)) & 8'((1 << dw) - 1);
        checks++;
        if ({obs_en, obs_busy, obs_done, obs_data} !== {3'b110, exp_d}) begin
          errors++;
          $display("FAIL tx dw=%0d byte=%0d ph=%0d en,busy,done,data=%b,%b,%b,%h expected 1,1,0,%h",
                   dw, b, p, obs_en, obs_busy, obs_done, obs_data, exp_d);
        end
        checks++;
        if (int'(obs_addr) > maxw) begin
          errors++;
          $display("FAIL addr_range dw=%0d buf_addr=%0d expected <= %0d", dw, obs_addr, maxw);
        end
        if (c == mid_at) begin
          set_start(dw, 1'b1);
          len = 11'(mid_len);
        end
        c++;
      end
    end
    for (int i = 0; i < nifg; i++) begin
      step();
      set_start(dw, 1'b0);
      checks++;
      if ({obs_en, obs_busy, obs_done, obs_data} !== {2'b01, (i == nifg - 1), 8'h00}) begin
        errors++;
        $display("FAIL ifg dw=%0d i=%0d en,busy,done,data=%b,%b,%b,%h expected 0,1,%0d,00",
                 dw, i, obs_en, obs_busy, obs_done, obs_data, (i == nifg - 1));
      end
    end
  endtask

  task automatic check_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      checks++;
      if ({obs_en, obs_busy, obs_done, obs_data} !== {3'b000, 8'h00}) begin
        errors++;
        $display("FAIL %s cyc=%0d en,busy,done,data=%b,%b,%b,%h expected 0,0,0,00",
                 tag, i, obs_en, obs_busy, obs_done, obs_data);
      end
    end
  endtask

  task automatic test_reset();
    sel = 4;
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({en4, busy4, done4, td4, addr4, en2, busy2, en8, busy8} !== 18'd0) begin
      errors++;
      $display("FAIL reset en,busy,done,data,addr=%b,%b,%b,%h,%h expected all 0",
               en4, busy4, done4, td4, addr4);
    end
    rst = 1'b0;
    check_idle("reset_idle", 3);
  endtask

  task automatic test_basic();
    mem[0] = 32'h0403_0201;
    run_frame(4, 4, -1, 0);
    check_idle("basic_after", 2);
  endtask

  task automatic test_check_vector();
    mem[0] = 32'h3433_3231;
    mem[1] = 32'h3837_3635;
    mem[2] = 32'h0000_0039;
    run_frame(4, 9, -1, 0);
    check_idle("vector_after", 2);
  endtask

  task automatic test_widths();
    mem[0] = 32'hDEAD_BEA5;
    run_frame(2, 1, -1, 0);
    check_idle("dw2_after", 2);
    run_frame(8, 1, -1, 0);
    check_idle("dw8_after", 2);
  endtask

  task automatic test_partial_word();
    mem[0] = 32'h1122_3344;
    mem[1] = 32'hFFFF_FF06;
    run_frame(4, 5, -1, 0);
    check_idle("partial_after", 2);
  endtask

  task automatic test_ignored_start();
    sel = 4;
    // len = 0 in IDLE must not start a frame.
    set_start(4, 1'b1);
    len = 11'd0;
    step();
    set_start(4, 1'b0);
    check_idle("len0", 4);
    for (int i = 0; i < 8; i++) mem[i] = $urandom;
    // start pulses during DATA (transmit cycle 20 is inside the payload).
    run_frame(4, 10, 20, 7);
    check_idle("mid_start_after", 2);
    run_frame(8, 12, 10, 0);
    check_idle("mid_start0_after", 2);
  endtask

  task automatic test_reset_mid();
    sel = 4;
    for (int i = 0; i < 8; i++) mem[i] = $urandom;
    set_start(4, 1'b1);
    len = 11'd12;
    step();
    set_start(4, 1'b0);
    for (int i = 0; i < 22; i++) step();      // well inside DATA
    rst = 1'b1;
    step();
    checks++;
    if ({en4, busy4, done4, addr4} !== 12'd0) begin
      errors++;
      $display("FAIL reset_mid en,busy,done,addr=%b,%b,%b,%h expected 0,0,0,000",
               en4, busy4, done4, addr4);
    end
    rst = 1'b0;
    check_idle("no_resume", 60);
    // rst has priority over a simultaneous start.
    rst = 1'b1;
    set_start(4, 1'b1);
    len = 11'd8;
    step();
    rst = 1'b0;
    set_start(4, 1'b0);
    check_idle("rst_prio", 5);
    run_frame(4, 12, -1, 0);
    check_idle("after_reset_frame", 2);
  endtask

  task automatic test_back_to_back();
    int dw;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    // Each frame's start is driven in the cycle after done.
    for (int f = 0; f < 6; f++) begin
      case ($urandom_range(0, 2))
        0:       dw = 2;
        1:       dw = 4;
        default: dw = 8;
      endcase
      run_frame(dw, int'($urandom_range(1, 40)), -1, 0);
      if (f % 3 == 2) begin
        check_idle("b2b_gap", 1);
      end
    end
    check_idle("b2b_after", 2);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'd0;
    #1;
    test_reset();
    test_basic();
    test_check_vector();
    test_widths();
    test_partial_word();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
